// File: rtl/series_eval_engine.sv
// series_eval_engine: fixed-point odd-power series evaluator.
// Computes y = sum_k (-1)^k * c[k] * x^(2k+1), k = 0..TERMS-1, in signed
// Q1.(WIDTH-1) using a run-time-loadable coefficient bank.
// Optional feature macro: SERIES_SAT_EN (saturate the accumulator on overflow
// instead of wrapping; ovf is flagged either way).
module series_eval_engine #(
    parameter int WIDTH = 16,
    parameter int TERMS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic             coef_wr,
    input  logic [2:0]       coef_addr,
    input  logic [WIDTH-1:0] coef_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    localparam int KW = (TERMS > 1) ? $clog2(TERMS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQR  = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic signed [WIDTH-1:0] xr_q, xr_d;
    logic signed [WIDTH-1:0] x2_q, x2_d;
    logic signed [WIDTH-1:0] pw_q, pw_d;
    logic signed [WIDTH-1:0] acc_q, acc_d;
    logic signed [WIDTH-1:0] result_q, result_d;
    logic                    ovf_q, ovf_d;
    logic [KW-1:0]           k_q, k_d;
    logic signed [WIDTH-1:0] c_q [TERMS];
    logic signed [WIDTH-1:0] c_d [TERMS];

    logic signed [WIDTH-1:0] term;
    logic signed [WIDTH:0]   sum_w;
    logic                    sum_ovf;
    logic signed [WIDTH-1:0] acc_step;
    logic                    last_term;

    // Q1.(WIDTH-1) multiply: full product, arithmetic shift, keep low WIDTH bits.
    // -1 x -1 wraps back to -1, which is the intended behaviour.
    function automatic logic signed [WIDTH-1:0] fx_mul(
        input logic signed [WIDTH-1:0] a,
        input logic signed [WIDTH-1:0] b
    );
        logic signed [2*WIDTH-1:0] p;
        p = a * b;
        p = p >>> (WIDTH - 1);
        return p[WIDTH-1:0];
    endfunction

    // Term datapath: one coefficient product and one add/sub per ACC cycle.
    always_comb begin
        term      = fx_mul(c_q[k_q], pw_q);
        // Even terms add, odd terms subtract; one guard bit catches overflow.
        if (k_q[0]) begin
            sum_w = {acc_q[WIDTH-1], acc_q} - {term[WIDTH-1], term};
        end else begin
            sum_w = {acc_q[WIDTH-1], acc_q} + {term[WIDTH-1], term};
        end
        sum_ovf   = sum_w[WIDTH] ^ sum_w[WIDTH-1];
        last_term = (k_q == KW'(TERMS - 1));
`ifdef SERIES_SAT_EN
        // Clamp toward the sign of the true (guard-bit) result.
        if (sum_ovf) begin
            acc_step = sum_w[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                                    : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            acc_step = sum_w[WIDTH-1:0];
        end
`else
        acc_step = sum_w[WIDTH-1:0];
`endif
    end

    // Controller: next state and datapath register updates.
    always_comb begin
        state_d  = state_q;
        xr_d     = xr_q;
        x2_d     = x2_q;
        pw_d     = pw_q;
        acc_d    = acc_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        k_d      = k_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    xr_d    = x;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    k_d     = '0;
                    state_d = SQR;
                end
            end
            SQR: begin
                x2_d    = fx_mul(xr_q, xr_q);
                pw_d    = xr_q;
                state_d = ACC;
            end
            ACC: begin
                acc_d = acc_step;
                if (sum_ovf) begin
                    ovf_d = 1'b1;
                end
                pw_d = fx_mul(pw_q, x2_q);
                k_d  = k_q + 1'b1;
                if (last_term) begin
                    result_d = acc_step;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Coefficient bank: writable only while idle, out-of-range indices ignored.
    always_comb begin
        for (int i = 0; i < TERMS; i++) begin
            c_d[i] = c_q[i];
            if (coef_wr && (state_q == IDLE) && (int'(coef_addr) == i)) begin
                c_d[i] = coef_data;
            end
        end
    end

    // State and datapath registers; reset aborts any evaluation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            xr_q     <= '0;
            x2_q     <= '0;
            pw_q     <= '0;
            acc_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            k_q      <= '0;
            for (int i = 0; i < TERMS; i++) begin
                c_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            xr_q     <= xr_d;
            x2_q     <= x2_d;
            pw_q     <= pw_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            k_q      <= k_d;
            for (int i = 0; i < TERMS; i++) begin
                c_q[i] <= c_d[i];
            end
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_series_eval_engine.sv
// Testbench for series_eval_engine (WIDTH=16, TERMS=4). Expected results come
// from an integer-arithmetic model of the series sum kept in the bench.
module tb_series_eval_engine;

    localparam int WIDTH = 16;
    localparam int TERMS = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] x = '0;
    logic             coef_wr = 1'b0;
    logic [2:0]       coef_addr = '0;
    logic [WIDTH-1:0] coef_data = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             ovf;

    int tests = 0;
    int fails = 0;

    // Coefficients the bench believes are loaded, as signed integers.
    longint mc [TERMS];

    series_eval_engine #(.WIDTH(WIDTH), .TERMS(TERMS)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .x         (x),
        .coef_wr   (coef_wr),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Interpret the low 16 bits as a signed value.
    function automatic longint sx(input longint v);
        longint r;
        r = v & 64'hFFFF;
        if (r > 32767) r = r - 65536;
        return r;
    endfunction

    // Fixed-point multiply: floor(a*b / 2^15), wrapped to 16 bits.
    function automatic longint fmul(input longint a, input longint b);
        longint p;
        p = a * b;
        p = p >>> 15;
        return sx(p);
    endfunction

    // Alternating odd-power series over the bench's coefficient copy.
    function automatic logic [15:0] model_eval(input logic [15:0] xv, output logic ovf_o);
        longint xs, x2, pw, acc, t, s;
        xs    = sx(longint'(xv));
        x2    = fmul(xs, xs);
        pw    = xs;
        acc   = 0;
        ovf_o = 1'b0;
        for (int k = 0; k < TERMS; k++) begin
            t = fmul(mc[k], pw);
            s = (k % 2 == 0) ? acc + t : acc - t;
            if (s > 32767 || s < -32768) begin
                ovf_o = 1'b1;
`ifdef SERIES_SAT_EN
                s = (s > 0) ? 32767 : -32768;
`else
                s = sx(s);
`endif
            end
            acc = s;
            pw  = fmul(pw, x2);
        end
        return 16'(acc);
    endfunction

    task automatic write_coef(input logic [2:0] a, input logic [15:0] d);
        coef_wr   = 1'b1;
        coef_addr = a;
        coef_data = d;
        tick();
        coef_wr = 1'b0;
        if (int'(a) < TERMS) mc[a] = sx(longint'(d));
    endtask

    // One evaluation, optionally with a coefficient write in the start cycle.
    task automatic run_eval(input string tag, input logic [15:0] xv,
                            input logic do_wr, input logic [2:0] wa, input logic [15:0] wd,
                            output logic [15:0] res_o, output logic ovf_o);
        logic [15:0] exp_r;
        logic        exp_o;
        int          n;
        start   = 1'b1;
        x       = xv;
        coef_wr = do_wr;
        coef_addr = wa;
        coef_data = wd;
        if (do_wr && int'(wa) < TERMS) mc[wa] = sx(longint'(wd));
        exp_r = model_eval(xv, exp_o);
        tick();
        start   = 1'b0;
        coef_wr = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (done) begin
                n = i;
                break;
            end
        end
        check({tag, "_latency"}, 32'(n), 32'(TERMS + 1));
        check({tag, "_result"}, 32'(result), 32'(exp_r));
        check({tag, "_ovf"}, 32'(ovf), 32'(exp_o));
        $display("[TB] %s x=%h result=%h ovf=%0d expected=%h/%0d", tag, xv, result, ovf, exp_r, exp_o);
        res_o = result;
        ovf_o = ovf;
        tick();
        check({tag, "_done_low"}, 32'(done), 32'd0);
        check({tag, "_busy_low"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [15:0] r;
        logic        o;
        int          dcnt;
        for (int i = 0; i < TERMS; i++) mc[i] = 0;

        // Reset state
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        tick();

        // Case 1: c0 = 0.5, x = 0.5 -> 0.25
        write_coef(3'd0, 16'h4000);
        run_eval("case1", 16'h4000, 1'b0, 3'd0, 16'h0, r, o);
        check("case1_const", 32'(r), 32'h2000);

        // Case 2: only the subtracted cubic term
        write_coef(3'd0, 16'h0000);
        write_coef(3'd1, 16'h4000);
        run_eval("case2", 16'h4000, 1'b0, 3'd0, 16'h0, r, o);
        check("case2_const", 32'(r), 32'hF800);

        // Case 3: overflow on the second term
        write_coef(3'd0, 16'h7FFF);
        write_coef(3'd1, 16'h8000);
        run_eval("case3", 16'h7FFF, 1'b0, 3'd0, 16'h0, r, o);
`ifdef SERIES_SAT_EN
        check("case3_const", 32'(r), 32'h7FFF);
`else
        check("case3_const", 32'(r), 32'hFFFB);
`endif
        check("case3_ovf_const", 32'(o), 32'd1);

        // Start pulses and a coefficient write while busy must be ignored
        write_coef(3'd0, 16'h4000);
        write_coef(3'd1, 16'h0000);
        start = 1'b1;
        x     = 16'h4000;
        tick();
        check("busy_ignore_busy", 32'(busy), 32'd1);
        coef_wr   = 1'b1;
        coef_addr = 3'd0;
        coef_data = 16'h1234;
        dcnt = 0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (done) dcnt++;
        end
        start   = 1'b0;
        coef_wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done) dcnt++;
        end
        check("busy_ignore_done_count", 32'(dcnt), 32'd1);
        check("busy_ignore_result", 32'(result), 32'h2000);
        check("busy_ignore_idle", 32'(busy), 32'd0);
        run_eval("readback", 16'h4000, 1'b0, 3'd0, 16'h0, r, o);
        check("readback_const", 32'(r), 32'h2000);

        // Asynchronous reset mid-evaluation
        start = 1'b1;
        x     = 16'h4000;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        dcnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done) dcnt++;
        end
        rst = 1'b0;
        for (int i = 0; i < TERMS; i++) mc[i] = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) dcnt++;
        end
        check("abort_no_done", 32'(dcnt), 32'd0);
        run_eval("after_rst_cleared", 16'h4000, 1'b0, 3'd0, 16'h0, r, o);
        check("after_rst_cleared_const", 32'(r), 32'h0000);
        write_coef(3'd0, 16'h4000);
        run_eval("after_rst", 16'h4000, 1'b0, 3'd0, 16'h0, r, o);
        check("after_rst_const", 32'(r), 32'h2000);

        // Out-of-range coefficient address is ignored
        write_coef(3'd5, 16'h7FFF);
        run_eval("addr5_x0", 16'h0000, 1'b0, 3'd0, 16'h0, r, o);
        check("addr5_x0_const", 32'(r), 32'h0000);
        run_eval("addr5_x", 16'h4000, 1'b0, 3'd0, 16'h0, r, o);
        check("addr5_x_const", 32'(r), 32'h2000);

        // Coefficient write in the start cycle is seen by that evaluation
        run_eval("wr_start", 16'h4000, 1'b1, 3'd0, 16'h2000, r, o);
        check("wr_start_const", 32'(r), 32'h1000);

        // Randomized runs against the model
        for (int it = 0; it < 24; it++) begin
            for (int k = 0; k < TERMS; k++) begin
                write_coef(3'(k), 16'($urandom));
            end
            run_eval($sformatf("rand%0d", it), 16'($urandom), 1'($urandom_range(0, 1)),
                     3'($urandom_range(0, 7)), 16'($urandom), r, o);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
